ka_encode_dat_1_3: RTL and testbench

Transmit-side packer for the 196-bit KA data bus: collects 32-bit payload words from an upstream valid/ready stream, assembles six of them into a 192-bit payload, prepends the 4-bit control nibble, and presents the beat as `t_ka_dat` with its own valid/ready handshake. It is the encoding counterpart of the KA decode stage. The decode stage takes `t_ka_dat[195:192]` as control and the full word as data, so the bit layout below is binding.

---
 rtl/ka_encode_dat_1_3.sv | 146 ++++++++++++++
 tb/tb_ka_encode_dat_1_3.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ka_encode_dat_1_3.sv
// ka_encode_dat_1_3: transmit-side packer for the 196-bit KA data bus.
//
// It collects WORDS upstream words of WORD_W bits and packs them into one payload.
// Word k of a beat lands at payload[WORD_W*k +: WORD_W], so word 0 sits at the LSBs.
// The control nibble captured with word 0 is placed above the payload.
// The finished beat is presented on a registered valid/ready output.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset_n   - asynchronous active-low reset
//   s_dat     - upstream payload word
//   s_ctrl    - control nibble, captured with word 0 and compared on later words
//   s_valid   - upstream word valid
//   s_last    - final word of a packet; closes the beat early
//   s_ready   - word accepted when s_valid & s_ready
//   t_ka_dat  - {ctrl, payload}
//   t_valid   - KA beat valid
//   t_ready   - downstream accept
//   ctrl_err  - sticky: s_ctrl disagreed with the captured nibble within a beat
module ka_encode_dat_1_3 #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 6,
  parameter int unsigned CTRL_W = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [WORD_W-1:0]                 s_dat,
  input  logic [CTRL_W-1:0]                 s_ctrl,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [CTRL_W+WORD_W*WORDS-1:0]    t_ka_dat,
  output logic                              t_valid,
  input  logic                              t_ready,
  output logic                              ctrl_err
);

  localparam int unsigned PayW = WORD_W * WORDS;
  localparam int unsigned CntW = 3;

  typedef enum logic [0:0] {StFill, StPend} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [PayW-1:0]          asm_q, asm_d;
  logic [CTRL_W-1:0]        asm_ctrl_q, asm_ctrl_d;
  logic [CTRL_W+PayW-1:0]   out_q, out_d;
  logic                     t_valid_q, t_valid_d;
  logic                     ctrl_err_q, ctrl_err_d;

  logic                     out_free;
  logic                     accept;
  logic                     beat_done;
  logic [PayW-1:0]          asm_with_word;
  logic [CTRL_W-1:0]        word_ctrl;

  assign out_free = !t_valid_q || t_ready;
  // Decoded from registered state only; no path from t_ready.
  assign s_ready  = (state_q == StFill);
  assign accept   = s_valid && s_ready;
  assign beat_done = accept && ((cnt_q == CntW'(WORDS - 1)) || s_last);

  // Word 0 starts from a cleared buffer so unwritten slots of a short beat read as zero.
  always_comb begin
    asm_with_word = (cnt_q == '0) ? '0 : asm_q;
    for (int k = 0; k < WORDS; k++) begin
      if (cnt_q == CntW'(k)) begin
        asm_with_word[WORD_W*k +: WORD_W] = s_dat;
      end
    end
    word_ctrl = (cnt_q == '0) ? s_ctrl : asm_ctrl_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    asm_ctrl_d = asm_ctrl_q;
    out_d      = out_q;
    t_valid_d  = t_valid_q;
    ctrl_err_d = ctrl_err_q;

    // Consumption without a replacing load empties the output register.
    if (t_valid_q && t_ready) begin
      t_valid_d = 1'b0;
    end

    unique case (state_q)
      StFill: begin
        if (accept) begin
          asm_d      = asm_with_word;
          asm_ctrl_d = word_ctrl;
          if ((cnt_q != '0) && (s_ctrl != asm_ctrl_q)) begin
            ctrl_err_d = 1'b1;
          end
          if (beat_done) begin
            if (out_free) begin
              out_d     = {word_ctrl, asm_with_word};
              t_valid_d = 1'b1;
              cnt_d     = '0;
            end else begin
              // Completed beat waits in asm until the output register frees up.
              state_d = StPend;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPend: begin
        if (out_free) begin
          out_d     = {asm_ctrl_q, asm_q};
          t_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFill;
      cnt_q      <= '0;
      asm_q      <= '0;
      asm_ctrl_q <= '0;
      out_q      <= '0;
      t_valid_q  <= 1'b0;
      ctrl_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      asm_ctrl_q <= asm_ctrl_d;
      out_q      <= out_d;
      t_valid_q  <= t_valid_d;
      ctrl_err_q <= ctrl_err_d;
    end
  end

  assign t_ka_dat = out_q;
  assign t_valid  = t_valid_q;
  assign ctrl_err = ctrl_err_q;

endmodule

// File: tb/tb_ka_encode_dat_1_3.sv
module tb_ka_encode_dat_1_3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  s_dat;
  logic [3:0]   s_ctrl;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic [195:0] t_ka_dat;
  logic         t_valid;
  logic         t_ready;
  logic         ctrl_err;

  int checks = 0;
  int failures = 0;
  int stalls = 0;
  int cyc = 0;
  logic [195:0] got_q[$];

  ka_encode_dat_1_3 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_dat    (s_dat),
    .s_ctrl   (s_ctrl),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .t_ka_dat (t_ka_dat),
    .t_valid  (t_valid),
    .t_ready  (t_ready),
    .ctrl_err (ctrl_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake signals are stable at the falling edge; record beats consumed at the next rise.
  always @(negedge clk) begin
    if (reset_n && t_valid && t_ready) got_q.push_back(t_ka_dat);
  end

  task automatic send(input logic [31:0] d, input logic [3:0] c, input logic l);
    logic ok;
    int n;
    s_dat = d; s_ctrl = c; s_last = l; s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = s_ready;
      if (!ok) stalls++;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout: word %h not accepted after %0d cycles (s_ready=%b, required 1)",
               d, n, s_ready);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_dat = '0; s_ctrl = '0; t_ready = 1'b1;
    #12;
    checks++; if (t_valid !== 1'b0) begin failures++;
      $display("FAIL reset_t_valid: got %b want 0", t_valid); end
    checks++; if (t_ka_dat !== 196'h0) begin failures++;
      $display("FAIL reset_t_ka_dat: got %h want 0", t_ka_dat); end
    checks++; if (s_ready !== 1'b1) begin failures++;
      $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    checks++; if (ctrl_err !== 1'b0) begin failures++;
      $display("FAIL reset_ctrl_err: got %b want 0", ctrl_err); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_beat;
    logic [195:0] exp;
    got_q.delete();
    t_ready = 1'b1;
    exp = '0; exp[195:192] = 4'hA;
    for (int i = 0; i < 6; i++) begin
      exp[32*i +: 32] = 32'(i);
      send(32'(i), 4'hA, 1'b0);
    end
    checks++; if (t_valid !== 1'b1) begin failures++;
      $display("FAIL full_t_valid: got %b want 1", t_valid); end
    checks++; if (t_ka_dat[195:192] !== 4'hA) begin failures++;
      $display("FAIL full_ctrl: got %h want a", t_ka_dat[195:192]); end
    checks++; if (t_ka_dat[31:0] !== 32'h0) begin failures++;
      $display("FAIL full_word0: got %h want 0", t_ka_dat[31:0]); end
    checks++; if (t_ka_dat[191:160] !== 32'h5) begin failures++;
      $display("FAIL full_word5: got %h want 5", t_ka_dat[191:160]); end
    checks++; if (ctrl_err !== 1'b0) begin failures++;
      $display("FAIL full_ctrl_err: got %b want 0", ctrl_err); end
    idle(3);
    checks++; if (got_q.size() != 1 || got_q[0] !== exp) begin failures++;
      $display("FAIL full_beat: got %0d beats want 1 of %h", got_q.size(), exp); end
  endtask

  task automatic test_short_packet;
    logic [195:0] exp;
    got_q.delete();
    exp = {4'h3, 128'h0, 32'h22, 32'h11};
    send(32'h11, 4'h3, 1'b0);
    send(32'h22, 4'h3, 1'b1);
    checks++; if (t_valid !== 1'b1 || t_ka_dat !== exp) begin failures++;
      $display("FAIL short_beat: got v=%b %h want v=1 %h", t_valid, t_ka_dat, exp); end
    idle(3);
    checks++; if (got_q.size() != 1) begin failures++;
      $display("FAIL short_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_back_pressure;
    logic [195:0] b1, b2;
    got_q.delete();
    t_ready = 1'b0;
    b1 = '0; b1[195:192] = 4'hC;
    b2 = '0; b2[195:192] = 4'hD;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) b1[32*i +: 32] = 32'h100 + 32'(i);
      else       b2[32*(i-6) +: 32] = 32'h100 + 32'(i);
      send(32'h100 + 32'(i), (i < 6) ? 4'hC : 4'hD, 1'b0);
      if (i == 8) begin
        checks++; if (t_valid !== 1'b1 || t_ka_dat !== b1) begin failures++;
          $display("FAIL bp_hold_mid: got v=%b %h want v=1 %h", t_valid, t_ka_dat, b1); end
      end
    end
    checks++; if (s_ready !== 1'b0) begin failures++;
      $display("FAIL bp_s_ready_drop: got %b want 0", s_ready); end
    idle(2);
    checks++; if (t_valid !== 1'b1 || t_ka_dat !== b1) begin failures++;
      $display("FAIL bp_hold: got v=%b %h want v=1 %h", t_valid, t_ka_dat, b1); end
    checks++; if (s_ready !== 1'b0) begin failures++;
      $display("FAIL bp_s_ready_low: got %b want 0", s_ready); end
    t_ready = 1'b1;
    idle(1);
    checks++; if (t_valid !== 1'b1 || t_ka_dat !== b2) begin failures++;
      $display("FAIL bp_replace: got v=%b %h want v=1 %h", t_valid, t_ka_dat, b2); end
    checks++; if (s_ready !== 1'b1) begin failures++;
      $display("FAIL bp_s_ready_back: got %b want 1", s_ready); end
    idle(3);
    checks++; if (got_q.size() != 2) begin failures++;
      $display("FAIL bp_count: got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== b1 || got_q[1] !== b2) begin failures++;
        $display("FAIL bp_order: got %h / %h want %h / %h", got_q[0], got_q[1], b1, b2); end
    end
  endtask

  task automatic test_streaming;
    logic [195:0] exp[10];
    int c0;
    got_q.delete();
    stalls = 0;
    t_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 60; i++) begin
      if (i % 6 == 0) begin exp[i/6] = '0; exp[i/6][195:192] = 4'(i / 6); end
      exp[i/6][32*(i%6) +: 32] = 32'hA000 + 32'(i);
      send(32'hA000 + 32'(i), 4'(i / 6), 1'b0);
    end
    checks++; if (cyc - c0 != 60) begin failures++;
      $display("FAIL stream_cycles: got %0d want 60", cyc - c0); end
    checks++; if (stalls != 0) begin failures++;
      $display("FAIL stream_s_ready: got %0d stall cycles want 0", stalls); end
    idle(3);
    checks++; if (got_q.size() != 10) begin failures++;
      $display("FAIL stream_count: got %0d want 10", got_q.size()); end
    else begin
      for (int b = 0; b < 10; b++) begin
        checks++; if (got_q[b] !== exp[b]) begin failures++;
          $display("FAIL stream_beat%0d: got %h want %h", b, got_q[b], exp[b]); end
      end
    end
  endtask

  task automatic test_ctrl_mismatch;
    logic [195:0] exp;
    got_q.delete();
    exp = '0; exp[195:192] = 4'h5;
    for (int i = 0; i < 6; i++) begin
      exp[32*i +: 32] = 32'h500 + 32'(i);
      send(32'h500 + 32'(i), (i == 2) ? 4'h6 : 4'h5, 1'b0);
      if (i == 1) begin
        checks++; if (ctrl_err !== 1'b0) begin failures++;
          $display("FAIL ctrl_err_early: got %b want 0", ctrl_err); end
      end
      if (i == 2) begin
        checks++; if (ctrl_err !== 1'b1) begin failures++;
          $display("FAIL ctrl_err_rise: got %b want 1", ctrl_err); end
      end
    end
    idle(3);
    checks++; if (ctrl_err !== 1'b1) begin failures++;
      $display("FAIL ctrl_err_sticky: got %b want 1", ctrl_err); end
    checks++; if (got_q.size() != 1 || got_q[0] !== exp) begin failures++;
      $display("FAIL ctrl_beat: got %0d beats want 1 of %h", got_q.size(), exp); end
  endtask

  task automatic test_reset_mid_beat;
    logic [195:0] exp;
    got_q.delete();
    for (int i = 0; i < 3; i++) send(32'hDEAD0000 + 32'(i), 4'h9, 1'b0);
    reset_n = 1'b0;
    #2;
    checks++; if (t_valid !== 1'b0 || t_ka_dat !== 196'h0 || ctrl_err !== 1'b0 || s_ready !== 1'b1)
    begin failures++;
      $display("FAIL mid_reset_outputs: got v=%b dat=%h err=%b rdy=%b want 0 0 0 1",
               t_valid, t_ka_dat, ctrl_err, s_ready); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    exp = '0; exp[195:192] = 4'h7;
    for (int i = 0; i < 6; i++) begin
      exp[32*i +: 32] = 32'h7700 + 32'(i);
      send(32'h7700 + 32'(i), 4'h7, 1'b0);
    end
    idle(3);
    checks++; if (got_q.size() != 1 || got_q[0] !== exp) begin failures++;
      $display("FAIL mid_reset_beat: got %0d beats want 1 of %h", got_q.size(), exp); end
  endtask

  initial begin
    test_reset;
    test_full_beat;
    test_short_packet;
    test_back_pressure;
    test_streaming;
    test_ctrl_mismatch;
    test_reset_mid_beat;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
